ahb_lite_slave_buffer: RTL and testbench

AHB-Lite slave that sits directly downstream of the AHB-Lite master interface and terminates its write and read transfers. It holds a small word-addressed buffer. It implements the standard pipelined address/data phases, programmable wait states and a two-cycle ERROR response. It flags each completed 4-word (128-bit) block so the consumer knows a full encrypted text block has landed.

---
 rtl/ahb_lite_slave_buffer.sv | 150 +++++++++++++++
 tb/tb_ahb_lite_slave_buffer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_slave_buffer.sv
// rtl/ahb_lite_slave_buffer.sv - AHB-Lite slave terminating transfers into a word buffer
//
// Pipelined AHB-Lite slave holding DEPTH_WORDS 32-bit words. Word transfers
// only; out-of-range, misaligned or non-word transfers get a two-cycle ERROR.
// Every completed write to the last word of a 4-word block emits a one-cycle
// block_valid pulse carrying the whole 128-bit block.
//
// Ports:
//   HCLK, HRESETn          clock, asynchronous active-low reset
//   HSEL, HADDR, HWRITE,   address-phase controls
//   HSIZE, HBURST, HTRANS
//   HWDATA                 write data (data phase)
//   HRDATA, HREADY, HRESP  data-phase response
//   block_valid            one-cycle pulse after a block's word 3 is written
//   block_index            index of the completed block
//   block_data             completed block, word 0 in bits [31:0]
module ahb_lite_slave_buffer #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 16,
  parameter int          WAIT_STATES = 0,
  localparam int         IDX_W       = $clog2(DEPTH_WORDS),
  localparam int         BLK_W       = (IDX_W > 2) ? IDX_W - 2 : 1
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               HSEL,
  input  logic [31:0]        HADDR,
  input  logic               HWRITE,
  input  logic [2:0]         HSIZE,
  input  logic [2:0]         HBURST,
  input  logic [1:0]         HTRANS,
  input  logic [31:0]        HWDATA,
  output logic [31:0]        HRDATA,
  output logic               HREADY,
  output logic               HRESP,
  output logic               block_valid,
  output logic [BLK_W-1:0]   block_index,
  output logic [127:0]       block_data
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  // WAIT is entered with the counter at WAIT_STATES-1 and left at zero,
  // giving exactly WAIT_STATES HREADY-low cycles.
  localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  state_t           state, state_n;
  logic [2:0]       ws_cnt, ws_cnt_n;
  logic             ph_write;
  logic [IDX_W-1:0] ph_index;
  logic [31:0]      mem [DEPTH_WORDS];

  logic [31:0]      offset;
  logic             addr_legal;
  logic             accept;
  logic             wr_done;
  logic [IDX_W-1:0] blk_base;
  logic             unused_bits;

  // A HADDR below BASE_ADDR wraps to a huge offset and fails the range test.
  assign offset     = HADDR - BASE_ADDR;
  assign addr_legal = (offset < 32'(4 * DEPTH_WORDS)) &&
                      (HADDR[1:0] == 2'b00) && (HSIZE == 3'b010);

  assign HREADY  = (state != ST_WAIT) && (state != ST_ERR1);
  assign HRESP   = (state == ST_ERR1) || (state == ST_ERR2);
  assign accept  = HSEL && HREADY && HTRANS[1];
  assign wr_done = (state == ST_DATA) && ph_write;

  // The write of a preceding transfer commits on the edge that opens this
  // read's data phase, so a combinational read already sees the new value.
  assign HRDATA = (((state == ST_WAIT) || (state == ST_DATA)) && !ph_write) ?
                  mem[ph_index] : 32'h0;

  assign blk_base    = ph_index & ~IDX_W'(3);
  assign unused_bits = ^{HBURST, HTRANS[0]};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= ST_IDLE;
      ws_cnt   <= 3'd0;
      ph_write <= 1'b0;
      ph_index <= '0;
    end else begin
      state  <= state_n;
      ws_cnt <= ws_cnt_n;
      if (accept) begin
        ph_write <= HWRITE;
        ph_index <= offset[IDX_W+1:2];
      end
    end
  end

  always_comb begin
    state_n  = state;
    ws_cnt_n = ws_cnt;
    case (state)
      ST_WAIT: begin
        if (ws_cnt == 3'd0) state_n = ST_DATA;
        else                ws_cnt_n = ws_cnt - 3'd1;
      end
      ST_ERR1: state_n = ST_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all drive HREADY high, so a new address
        // phase may be taken here.
        if (accept) begin
          if (!addr_legal) begin
            state_n = ST_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_n = ST_DATA;
          end else begin
            state_n  = ST_WAIT;
            ws_cnt_n = WS_LOAD;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'h0;
      block_valid <= 1'b0;
      block_index <= '0;
      block_data  <= '0;
    end else begin
      block_valid <= 1'b0;
      if (wr_done) begin
        mem[ph_index] <= HWDATA;
        if (ph_index[1:0] == 2'b11) begin
          block_valid <= 1'b1;
          block_index <= BLK_W'(ph_index >> 2);
          block_data  <= {HWDATA,
                          mem[blk_base | IDX_W'(2)],
                          mem[blk_base | IDX_W'(1)],
                          mem[blk_base]};
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_slave_buffer.sv
// tb/tb_ahb_lite_slave_buffer.sv - bench for ahb_lite_slave_buffer (0 and 2 wait states)
module tb_ahb_lite_slave_buffer;

  typedef struct packed {
    logic [1:0]  trans;
    logic        hsel;
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
  } xfer_t;

  localparam logic [1:0] ID = 2'b00, BZ = 2'b01, NS = 2'b10, SQ = 2'b11;

  logic        tb_HCLK;
  logic        HRESETn;
  logic        bus_hsel;
  int          sel;
  logic [31:0] HADDR, HWDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [1:0]  HTRANS;

  logic [31:0]  hrdata0, hrdata2;
  logic         hready0, hready2, hresp0, hresp2, bv0, bv2;
  logic [1:0]   bi0, bi2;
  logic [127:0] bd0, bd2;

  ahb_lite_slave_buffer #(.BASE_ADDR(32'h0), .DEPTH_WORDS(16), .WAIT_STATES(0)) u_dut0 (
    .HCLK(tb_HCLK), .HRESETn(HRESETn), .HSEL(bus_hsel && (sel == 0)),
    .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HTRANS(HTRANS), .HWDATA(HWDATA), .HRDATA(hrdata0), .HREADY(hready0),
    .HRESP(hresp0), .block_valid(bv0), .block_index(bi0), .block_data(bd0)
  );

  ahb_lite_slave_buffer #(.BASE_ADDR(32'h0), .DEPTH_WORDS(16), .WAIT_STATES(2)) u_dut2 (
    .HCLK(tb_HCLK), .HRESETn(HRESETn), .HSEL(bus_hsel && (sel == 1)),
    .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HTRANS(HTRANS), .HWDATA(HWDATA), .HRDATA(hrdata2), .HREADY(hready2),
    .HRESP(hresp2), .block_valid(bv2), .block_index(bi2), .block_data(bd2)
  );

  initial tb_HCLK = 1'b0;
  always #5 tb_HCLK = ~tb_HCLK;

  int           n_checks = 0;
  int           n_errors = 0;
  xfer_t        q[$];
  logic [31:0]  mem_m [2][16];
  bit           exp_bv [2];
  int           exp_bi [2];
  logic [127:0] exp_bd [2];
  int           pulses [2];
  logic [127:0] seen_bd [2];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push(input logic [1:0] tr, input logic hs, input logic wr,
                               input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    xfer_t x;
    x.trans = tr; x.hsel = hs; x.write = wr; x.addr = a; x.size = sz; x.data = d;
    q.push_back(x);
  endfunction

  function automatic bit legal(input xfer_t x);
    return (x.addr < 32'd64) && (x.addr[1:0] == 2'b00) && (x.size == 3'b010);
  endfunction

  function automatic void clear_model();
    for (int j = 0; j < 2; j++) begin
      for (int w = 0; w < 16; w++) mem_m[j][w] = 32'h0;
      exp_bv[j] = 1'b0;
    end
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_hready0"}, hready0, 1);
    chk({tag, "_hready2"}, hready2, 1);
    chk({tag, "_hresp0"},  hresp0, 0);
    chk({tag, "_hresp2"},  hresp2, 0);
    chk({tag, "_hrdata0"}, hrdata0, 0);
    chk({tag, "_hrdata2"}, hrdata2, 0);
    chk({tag, "_bv0"},     bv0, 0);
    chk({tag, "_bv2"},     bv2, 0);
    chk({tag, "_bidx"},    {bi0, bi2}, 0);
    chk({tag, "_bdata"},   bd0 | bd2, 0);
  endtask

  // Plays the queued address phases onto DUT s as a pipelined master would,
  // predicting each data-phase cycle from the transfer rules alone.
  task automatic run_q(input int s);
    int    i = 0;
    int    k = 0;
    int    extra = 2;
    int    ws;
    bit    dpv = 0;
    bit    dp_ok = 0;
    bit    drove;
    bit    exp_rdy, exp_rsp;
    int    idx, b;
    xfer_t dp;
    dp  = '0;
    sel = s;
    ws  = (s == 0) ? 0 : 2;
    while (i < q.size() || dpv || extra > 0) begin
      if (!(i < q.size() || dpv)) extra--;
      // During an ERROR response the master cancels to IDLE.
      drove = (i < q.size()) && !(dpv && !dp_ok);
      if (drove) begin
        bus_hsel = q[i].hsel; HTRANS = q[i].trans; HADDR = q[i].addr;
        HWRITE = q[i].write; HSIZE = q[i].size;
      end else begin
        bus_hsel = 1'b0; HTRANS = ID; HADDR = $urandom; HWRITE = 1'b0; HSIZE = 3'b010;
      end
      HWDATA = (dpv && dp.write) ? dp.data : $urandom;
      @(negedge tb_HCLK);
      if (!dpv) begin
        exp_rdy = 1'b1; exp_rsp = 1'b0;
      end else if (!dp_ok) begin
        exp_rdy = (k == 1); exp_rsp = 1'b1;
      end else begin
        exp_rdy = (k >= ws); exp_rsp = 1'b0;
      end
      chk("hready", (s == 0) ? hready0 : hready2, exp_rdy);
      chk("hresp",  (s == 0) ? hresp0 : hresp2, exp_rsp);
      if (!dpv || !dp_ok)
        chk("hrdata_idle", (s == 0) ? hrdata0 : hrdata2, 0);
      else if (!dp.write)
        chk("hrdata_read", (s == 0) ? hrdata0 : hrdata2, mem_m[s][dp.addr[5:2]]);
      chk("block_valid0", bv0, exp_bv[0]);
      chk("block_valid2", bv2, exp_bv[1]);
      if (bv0) begin pulses[0]++; seen_bd[0] = bd0; end
      if (bv2) begin pulses[1]++; seen_bd[1] = bd2; end
      if (exp_bv[s]) begin
        chk("block_index", (s == 0) ? bi0 : bi2, exp_bi[s]);
        chk("block_data",  (s == 0) ? bd0 : bd2, exp_bd[s]);
      end
      exp_bv[0] = 1'b0;
      exp_bv[1] = 1'b0;
      if (dpv && exp_rdy) begin
        if (dp_ok && dp.write) begin
          idx = int'(dp.addr[5:2]);
          mem_m[s][idx] = dp.data;
          if (idx % 4 == 3) begin
            b = idx / 4;
            exp_bv[s] = 1'b1;
            exp_bi[s] = b;
            exp_bd[s] = {mem_m[s][4*b+3], mem_m[s][4*b+2], mem_m[s][4*b+1], mem_m[s][4*b]};
          end
        end
        dpv = 1'b0;
      end else if (dpv) begin
        k++;
      end
      if (drove && exp_rdy) begin
        if (q[i].hsel && q[i].trans[1]) begin
          dp = q[i]; dpv = 1'b1; dp_ok = legal(q[i]); k = 0;
        end
        i++;
      end
      @(posedge tb_HCLK);
      #1;
    end
    q.delete();
  endtask

  int          rs, kind, p0;
  logic [31:0] ra;

  initial begin
    sel = 0; bus_hsel = 1'b0; HTRANS = ID; HADDR = 32'h0; HWRITE = 1'b0;
    HSIZE = 3'b010; HBURST = 3'b011; HWDATA = 32'h0;
    pulses[0] = 0; pulses[1] = 0;
    seen_bd[0] = '0; seen_bd[1] = '0;
    clear_model();
    HRESETn = 1'b0;
    #1;
    chk_reset_outputs("reset");
    repeat (2) @(posedge tb_HCLK);
    @(negedge tb_HCLK);
    HRESETn = 1'b1;
    @(posedge tb_HCLK);
    #1;

    // INCR4 write burst, zero wait states
    push(NS, 1, 1, 32'h0, 3'b010, 32'h11111111);
    push(SQ, 1, 1, 32'h4, 3'b010, 32'h22222222);
    push(SQ, 1, 1, 32'h8, 3'b010, 32'h33333333);
    push(SQ, 1, 1, 32'hC, 3'b010, 32'h44444444);
    push(ID, 1, 0, 32'h0, 3'b010, 32'h0);
    run_q(0);
    chk("incr4_pulses", pulses[0], 1);
    chk("incr4_block", seen_bd[0], 128'h44444444_33333333_22222222_11111111);

    // Same burst into the wait-state instance, then a single read of 0x8
    push(NS, 1, 1, 32'h0, 3'b010, 32'h11111111);
    push(SQ, 1, 1, 32'h4, 3'b010, 32'h22222222);
    push(SQ, 1, 1, 32'h8, 3'b010, 32'h33333333);
    push(SQ, 1, 1, 32'hC, 3'b010, 32'h44444444);
    push(ID, 1, 0, 32'h0, 3'b010, 32'h0);
    push(NS, 1, 0, 32'h8, 3'b010, 32'h0);
    run_q(1);

    // Write immediately followed by a read of the same word
    push(NS, 1, 1, 32'h4, 3'b010, 32'hDEADBEEF);
    push(NS, 1, 0, 32'h4, 3'b010, 32'h0);
    run_q(0);
    push(NS, 1, 1, 32'h4, 3'b010, 32'hDEADBEEF);
    push(NS, 1, 0, 32'h4, 3'b010, 32'h0);
    run_q(1);

    // ERROR cases leave the buffer untouched
    p0 = pulses[0];
    push(NS, 1, 1, 32'h40, 3'b010, 32'h0BAD0BAD);
    push(NS, 1, 1, 32'h0,  3'b000, 32'h0BAD0000);
    push(NS, 1, 1, 32'h3E, 3'b010, 32'h0BAD003E);
    push(NS, 1, 0, 32'h0,  3'b010, 32'h0);
    run_q(0);
    chk("error_no_pulse", pulses[0], p0);

    // BUSY inside a burst and an unselected NONSEQ write
    push(NS, 1, 1, 32'h20, 3'b010, 32'hA0A0A0A0);
    push(BZ, 1, 1, 32'h24, 3'b010, 32'hB1B1B1B1);
    push(SQ, 1, 1, 32'h24, 3'b010, 32'hA1A1A1A1);
    push(NS, 0, 1, 32'h3C, 3'b010, 32'hC3C3C3C3);
    push(NS, 1, 0, 32'h3C, 3'b010, 32'h0);
    push(NS, 1, 0, 32'h24, 3'b010, 32'h0);
    run_q(0);
    chk("busy_no_pulse", pulses[0], p0);

    // Asynchronous reset in the middle of a write burst
    sel = 1; bus_hsel = 1'b1; HTRANS = NS; HWRITE = 1'b1; HADDR = 32'h8; HSIZE = 3'b010;
    @(posedge tb_HCLK);
    #1;
    HTRANS = SQ; HADDR = 32'hC; HWDATA = 32'hCAFEF00D;
    #2;
    HRESETn = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    clear_model();
    bus_hsel = 1'b0; HTRANS = ID;
    @(negedge tb_HCLK);
    HRESETn = 1'b1;
    @(posedge tb_HCLK);
    #1;
    push(NS, 1, 0, 32'h8, 3'b010, 32'h0);
    run_q(1);
    push(NS, 1, 0, 32'h8, 3'b010, 32'h0);
    run_q(0);

    // Randomized traffic
    for (int r = 0; r < 8; r++) begin
      rs = int'($urandom_range(0, 1));
      for (int t = 0; t < 14; t++) begin
        kind = int'($urandom_range(0, 11));
        ra = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        case (kind)
          0:       push(NS, 1, 1'($urandom), 32'h40 + ra, 3'b010, $urandom);
          1:       push(NS, 1, 1'($urandom), ra | 32'h2, 3'b010, $urandom);
          2:       push(NS, 1, 1, ra, 3'b001, $urandom);
          3:       push(BZ, 1, 1, ra, 3'b010, $urandom);
          4:       push(NS, 0, 1, ra, 3'b010, $urandom);
          5, 6, 7: push(SQ, 1, 0, ra, 3'b010, 32'h0);
          default: push((t == 0) ? NS : SQ, 1, 1, ra, 3'b010, $urandom);
        endcase
      end
      run_q(rs);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

endmodule
